// File: rtl/rgb_pkg.sv
// Shared constants for the RGB LED colour path: channel width, marker
// threshold and byte-field positions of the GRB input and GRBW output words.
package rgb_pkg;

   localparam int unsigned COLOR_BITS    = 8;
   localparam logic [31:0] MARKER_THRESH = 32'h00FF_FFFF;

   // GRB input word: {8'h00, G, R, B}
   localparam int unsigned IN_G_LSB  = 16;
   localparam int unsigned IN_R_LSB  = 8;
   localparam int unsigned IN_B_LSB  = 0;

   // GRBW output word: {G', R', B', W}
   localparam int unsigned OUT_G_LSB = 24;
   localparam int unsigned OUT_R_LSB = 16;
   localparam int unsigned OUT_B_LSB = 8;
   localparam int unsigned OUT_W_LSB = 0;

endpackage

// File: rtl/rgb_min3.sv
// Combinational unsigned minimum of three channel values (two comparators).
module rgb_min3 #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_min_c
);

   logic [W-1:0] w_ab;

   assign w_ab    = (i_a < i_b)  ? i_a  : i_b;
   assign o_min_c = (w_ab < i_c) ? w_ab : i_c;

endmodule

// File: rtl/rgb2rgbw_conv.sv
// Two-stage GRB -> GRBW converter: pops the upstream FIFO, extracts
// W = min(G,R,B) and presents the result through a show-ahead interface.
module rgb2rgbw_conv
   import rgb_pkg::*;
#(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned COLOR_BITS = rgb_pkg::COLOR_BITS,
   parameter int unsigned EXTRACT_W  = 1,
   parameter int unsigned CNT_BITS   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_rd_fifo_empty,
   input  logic [DATA_SIZE-1:0] in_rd_fifo_data,
   output logic                 out_rd_fifo_en,
   input  logic                 in_rd_en,
   output logic                 out_empty,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_stream_reset,
   output logic [CNT_BITS-1:0]  out_led_count
);

   logic                  r_s1_valid;
   logic                  r_s1_marker;
   logic [COLOR_BITS-1:0] r_s1_g;
   logic [COLOR_BITS-1:0] r_s1_r;
   logic [COLOR_BITS-1:0] r_s1_b;
   logic [COLOR_BITS-1:0] r_s1_m;

   logic                  r_s2_valid;
   logic                  r_s2_marker;
   logic [DATA_SIZE-1:0]  r_s2_data;

   logic [CNT_BITS-1:0]   r_led_count;

   logic                  w_s1_load;
   logic                  w_s2_load;
   logic                  w_out_pop;
   logic                  w_in_marker;
   logic [COLOR_BITS-1:0] w_in_g;
   logic [COLOR_BITS-1:0] w_in_r;
   logic [COLOR_BITS-1:0] w_in_b;
   logic [COLOR_BITS-1:0] w_min;
   logic [COLOR_BITS-1:0] w_m;
   logic [DATA_SIZE-1:0]  w_s2_next;

   // Flow control; pops are suppressed while reset is held
   assign w_s2_load      = r_s1_valid & (~r_s2_valid | in_rd_en);
   assign w_s1_load      = rst & ~in_rd_fifo_empty & (~r_s1_valid | w_s2_load);
   assign w_out_pop      = r_s2_valid & in_rd_en;
   assign out_rd_fifo_en = w_s1_load;

   assign w_in_marker = in_rd_fifo_data > DATA_SIZE'(MARKER_THRESH);
   assign w_in_g      = in_rd_fifo_data[IN_G_LSB +: COLOR_BITS];
   assign w_in_r      = in_rd_fifo_data[IN_R_LSB +: COLOR_BITS];
   assign w_in_b      = in_rd_fifo_data[IN_B_LSB +: COLOR_BITS];

   rgb_min3 #(.W(COLOR_BITS)) u_min3 (
      .i_a     (w_in_g),
      .i_b     (w_in_r),
      .i_c     (w_in_b),
      .o_min_c (w_min)
   );

   assign w_m = (EXTRACT_W != 0) ? w_min : '0;

   // Stage 1: latch decoded channels, marker flag and channel minimum
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_marker <= 1'b0;
         r_s1_g      <= '0;
         r_s1_r      <= '0;
         r_s1_b      <= '0;
         r_s1_m      <= '0;
      end else if (w_s1_load) begin
         r_s1_valid  <= 1'b1;
         r_s1_marker <= w_in_marker;
         r_s1_g      <= w_in_g;
         r_s1_r      <= w_in_r;
         r_s1_b      <= w_in_b;
         r_s1_m      <= w_m;
      end else if (w_s2_load) begin
         r_s1_valid  <= 1'b0;
      end
   end

   // m never exceeds any channel, so the subtractions cannot underflow
   always_comb begin
      w_s2_next = '0;
      if (!r_s1_marker) begin
         w_s2_next[OUT_G_LSB +: COLOR_BITS] = r_s1_g - r_s1_m;
         w_s2_next[OUT_R_LSB +: COLOR_BITS] = r_s1_r - r_s1_m;
         w_s2_next[OUT_B_LSB +: COLOR_BITS] = r_s1_b - r_s1_m;
         w_s2_next[OUT_W_LSB +: COLOR_BITS] = r_s1_m;
      end
   end

   // Stage 2: output register, reloads from S1 in the same clock it is popped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_marker <= 1'b0;
         r_s2_data   <= '0;
      end else if (w_s2_load) begin
         r_s2_valid  <= 1'b1;
         r_s2_marker <= r_s1_marker;
         r_s2_data   <= w_s2_next;
      end else if (w_out_pop) begin
         r_s2_valid  <= 1'b0;
         r_s2_marker <= 1'b0;
      end
   end

   // LED words delivered since the last marker, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_led_count <= '0;
      end else if (w_out_pop) begin
         if (r_s2_marker) begin
            r_led_count <= '0;
         end else if (r_led_count != {CNT_BITS{1'b1}}) begin
            r_led_count <= r_led_count + CNT_BITS'(1);
         end
      end
   end

   assign out_empty        = ~r_s2_valid;
   assign out_data         = r_s2_data;
   assign out_stream_reset = r_s2_marker;
   assign out_led_count    = r_led_count;

endmodule

// File: tb/tb_rgb2rgbw_conv.sv
// Scoreboard bench for rgb2rgbw_conv: a queue models the upstream FIFO and a
// second queue holds expected outputs; a pass-through build shares the inputs.
module tb_rgb2rgbw_conv;

   typedef struct {
      logic [31:0] d;
      logic        sr;
      logic [31:0] pt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_rd_fifo_empty;
   logic [31:0] in_rd_fifo_data;
   logic        in_rd_en;
   logic        out_rd_fifo_en;
   logic        out_empty;
   logic [31:0] out_data;
   logic        out_stream_reset;
   logic [15:0] out_led_count;
   logic        pt_rd_fifo_en;
   logic        pt_empty;
   logic [31:0] pt_data;
   logic        pt_stream_reset;
   logic [3:0]  pt_led_count;

   logic [31:0] fifo_q[$];
   exp_t        exp_q[$];
   int          total;
   int          bad;
   int          fifo_pulses;
   int          out_pops;
   logic [15:0] exp_cnt;
   logic [3:0]  exp_cnt_pt;

   rgb2rgbw_conv dut (
      .clk              (clk),
      .rst              (rst),
      .in_rd_fifo_empty (in_rd_fifo_empty),
      .in_rd_fifo_data  (in_rd_fifo_data),
      .out_rd_fifo_en   (out_rd_fifo_en),
      .in_rd_en         (in_rd_en),
      .out_empty        (out_empty),
      .out_data         (out_data),
      .out_stream_reset (out_stream_reset),
      .out_led_count    (out_led_count)
   );

   rgb2rgbw_conv #(.EXTRACT_W(0), .CNT_BITS(4)) dut_pt (
      .clk              (clk),
      .rst              (rst),
      .in_rd_fifo_empty (in_rd_fifo_empty),
      .in_rd_fifo_data  (in_rd_fifo_data),
      .out_rd_fifo_en   (pt_rd_fifo_en),
      .in_rd_en         (in_rd_en),
      .out_empty        (pt_empty),
      .out_data         (pt_data),
      .out_stream_reset (pt_stream_reset),
      .out_led_count    (pt_led_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t       e;
      logic [7:0] g, r, b, m;
      g = w[23:16];
      r = w[15:8];
      b = w[7:0];
      if (w > 32'h00FF_FFFF) begin
         e.d  = 32'h0;
         e.sr = 1'b1;
         e.pt = 32'h0;
      end else begin
         m = g;
         if (r < m) m = r;
         if (b < m) m = b;
         e.d  = {8'(g - m), 8'(r - m), 8'(b - m), m};
         e.sr = 1'b0;
         e.pt = {g, r, b, 8'h00};
      end
      return e;
   endfunction

   task automatic drive_fifo();
      in_rd_fifo_empty = (fifo_q.size() == 0);
      in_rd_fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
   endtask

   task automatic push(input logic [31:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(model(w));
      drive_fifo();
   endtask

   // One clock: called at a negedge with inputs set; returns at the next negedge
   task automatic cycle();
      logic do_fifo;
      logic do_out;
      exp_t e;
      #1;
      do_fifo = out_rd_fifo_en;
      do_out  = in_rd_en && !out_empty;
      chk("pt_fifo_en", 32'(pt_rd_fifo_en), 32'(out_rd_fifo_en));
      if (do_out) begin
         out_pops++;
         if (exp_q.size() == 0) begin
            chk("extra_out", 32'(1), 32'(0));
         end else begin
            e = exp_q.pop_front();
            chk("data", out_data, e.d);
            chk("srst", 32'(out_stream_reset), 32'(e.sr));
            chk("pt_data", pt_data, e.pt);
            chk("pt_srst", 32'(pt_stream_reset), 32'(e.sr));
            if (e.sr) begin
               exp_cnt    = 16'h0;
               exp_cnt_pt = 4'h0;
            end else begin
               if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
               if (exp_cnt_pt != 4'hF) exp_cnt_pt = exp_cnt_pt + 4'h1;
            end
         end
      end
      @(posedge clk);
      if (do_fifo) begin
         fifo_pulses++;
         void'(fifo_q.pop_front());
      end
      @(negedge clk);
      drive_fifo();
      chk("cnt", 32'(out_led_count), 32'(exp_cnt));
      chk("pt_cnt", 32'(pt_led_count), 32'(exp_cnt_pt));
      chk("pt_empty", 32'(pt_empty), 32'(out_empty));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      int inflight;
      total       = 0;
      bad         = 0;
      fifo_pulses = 0;
      out_pops    = 0;
      exp_cnt     = 16'h0;
      exp_cnt_pt  = 4'h0;
      rst         = 1'b0;
      in_rd_en    = 1'b1;
      drive_fifo();

      // Reset state, with a word waiting upstream and in_rd_en high
      repeat (2) @(negedge clk);
      push(32'h0010_2030);
      #1;
      chk("rst_empty", 32'(out_empty), 32'(1));
      chk("rst_data", out_data, 32'h0);
      chk("rst_srst", 32'(out_stream_reset), 32'(0));
      chk("rst_cnt", 32'(out_led_count), 32'(0));
      chk("rst_fifo_en", 32'(out_rd_fifo_en), 32'(0));

      // First pop on the first clock after release; output two clocks later
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("first_pop", 32'(out_rd_fifo_en), 32'(1));
      cycle();
      chk("lat_n1_empty", 32'(out_empty), 32'(1));
      cycle();
      chk("lat_n2_empty", 32'(out_empty), 32'(0));
      drain();

      // White, black, boundary marker, LED, marker and random LED words
      push(32'h00FF_FFFF);
      push(32'h0000_0000);
      push(32'h0100_0000);
      push(32'h00AA_BBCC);
      push(32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) push({8'h00, 24'($urandom)});
      drain();

      // Backpressure: only two words absorbed, then eight outputs without gaps
      @(negedge clk);
      in_rd_en = 1'b0;
      for (int i = 0; i < 8; i++) push(32'h0001_0203 + 32'(i * 32'h0011_0507));
      fifo_pulses = 0;
      repeat (10) cycle();
      chk("bp_pulses", 32'(fifo_pulses), 32'(2));
      in_rd_en = 1'b1;
      out_pops = 0;
      repeat (8) cycle();
      chk("bp_nogap", 32'(out_pops), 32'(8));
      drain();

      // Pass-through counter saturates at 15, then a marker clears both counts
      for (int i = 0; i < 18; i++) push(32'h0030_2010 + 32'(i));
      drain();
      chk("sat_pt", 32'(pt_led_count), 32'(15));
      push(32'h8000_0000);
      drain();
      chk("sat_clear", 32'(out_led_count), 32'(0));

      // Reset with both stages full: in-flight words dropped
      in_rd_en = 1'b0;
      push(32'h0011_2233);
      push(32'h0044_5566);
      push(32'h0077_8899);
      push(32'h00CC_DDEE);
      repeat (3) cycle();
      rst = 1'b0;
      #1;
      chk("mid_rst_empty", 32'(out_empty), 32'(1));
      chk("mid_rst_cnt", 32'(out_led_count), 32'(0));
      inflight = exp_q.size() - fifo_q.size();
      chk("mid_rst_inflight", 32'(inflight), 32'(2));
      for (int i = 0; i < inflight; i++) void'(exp_q.pop_front());
      exp_cnt    = 16'h0;
      exp_cnt_pt = 4'h0;
      @(negedge clk);
      repeat (2) cycle();
      rst      = 1'b1;
      in_rd_en = 1'b1;
      drain();
      chk("end_empty", 32'(out_empty), 32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rgb2rgbw_conv.md
Name: rgb2rgbw_conv

Overview:
- Colour-conversion stage between the async_fifo read side and rgb_sotp.
- Pops 24-bit GRB LED words and stream-reset markers from the FIFO.
- Extracts a white channel, W = min(R,G,B), and subtracts it from each colour.
- Presents 32-bit GRBW words through a show-ahead FIFO-style interface that rgb_sotp drains.

Parameters:
- DATA_SIZE, 32, width of input and output words; fixed at 32.
- COLOR_BITS, 8, bits per colour channel.
- EXTRACT_W, 1, 1 = min-extraction; 0 = pass-through with W = 0.
- CNT_BITS, 16, width of out_led_count.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset (low = reset).
- in_rd_fifo_empty  in  1  upstream FIFO empty.
- in_rd_fifo_data  in  32  upstream show-ahead data; valid whenever in_rd_fifo_empty=0.
- out_rd_fifo_en  out  1  pops one upstream word this clock.
- in_rd_en  in  1  downstream pop of out_data.
- out_empty  out  1  no converted word available.
- out_data  out  32  GRBW word {G',R',B',W}; valid while out_empty=0.
- out_stream_reset  out  1  qualifies out_data: 1 = stream-reset marker, out_data=0.
- out_led_count  out  CNT_BITS  LED words emitted since last marker; saturates at max.

Behaviour:
- Reset (rst low, asynchronous): all stage valids=0; out_empty=1; out_data=0; out_stream_reset=0; out_led_count=0; out_rd_fifo_en=0 while rst low.
- Input decode:
  - word <= 0x00FFFFFF is LED data: G=[23:16], R=[15:8], B=[7:0].
  - any word > 0x00FFFFFF is a stream-reset marker.
- Pipeline, two registered stages:
  - S1 latches G,R,B, the marker flag and m = min(G,R,B). Two 8-bit comparators; unsigned.
  - S2 latches G-m, R-m, B-m, m as {G',R',B',W}. Subtraction never underflows.
  - EXTRACT_W=0: m forced to 0, so out_data = {G,R,B,8'h00}.
  - Marker: S2 data = 0, flag set.
- Flow control:
  - s2_load = s1_valid & (~s2_valid | in_rd_en).
  - s1_load = ~in_rd_fifo_empty & (~s1_valid | s2_load).
  - out_rd_fifo_en = s1_load, combinational.
  - out_empty = ~s2_valid.
  - in_rd_en while out_empty=1 is ignored.
- Latency: word popped in cycle N appears with out_empty=0 in cycle N+2.
- Throughput: 1 word/clk when in_rd_en is held high.
- Backpressure (in_rd_en=0):
  - S2 holds; S1 fills.
  - Exactly 2 words are absorbed, then out_rd_fifo_en stays 0.
  - No loss or duplication.
- Simultaneous pop and refill: S2 reloads from S1 in the same clock; no bubble.
- out_led_count:
  - +1 on each in_rd_en pop of an LED word; saturates at 2^CNT_BITS-1.
  - Cleared to 0 on pop of a marker.
- Upstream empty mid-stream: valids drain; out_empty rises after the last word is popped.
- Reset mid-operation: in-flight words are discarded; no partial word is emitted after release.
- First pop is possible on the first clock after rst goes high.

Decomposition:
- Shared package rgb_pkg:
  - COLOR_BITS.
  - MARKER_THRESH = 32'h00FFFFFF.
  - Byte-field positions for the GRB input and GRBW output.
- One sub-module, rgb_min3: combinational 3-input unsigned min, instantiated in S1.
- Flow control and registers stay in rgb2rgbw_conv.

Test Plan:
- Basic conversion: 0x00102030, in_rd_en=1 -> out_data=0x00102010, out_stream_reset=0; out_empty falls 2 clocks after pop.
- Full white: 0x00FFFFFF -> 0x000000FF. Black: 0x00000000 -> 0x00000000.
- Marker: 0x00AABBCC, then 0xFFFFFFFF.
  - After popping 0x00AABBCC: out_led_count=1.
  - Marker presents out_stream_reset=1, out_data=0.
  - After marker pop: out_led_count=0.
- Backpressure: 8 words queued, in_rd_en=0 for 10 clocks -> exactly 2 out_rd_fifo_en pulses. Release -> 8 outputs in order, one per clock, no gaps.
- EXTRACT_W=0 build: 0x00102030 -> 0x10203000.
- Reset mid-stream: rst low with S1 and S2 valid -> out_empty=1 and out_led_count=0 immediately. After release, the next queued FIFO word is the first output.
